// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multicycle CPU control path: FSM states, opcode
// classes, ALU function codes and datapath mux selects.
package mc_cpu_pkg;

  localparam int STATE_W = 4;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_EXEC_R = 4'd3;
  localparam state_t S_EXEC_I = 4'd4;
  localparam state_t S_WB_ALU = 4'd5;
  localparam state_t S_ADDR   = 4'd6;
  localparam state_t S_MEMRD  = 4'd7;
  localparam state_t S_WB_MEM = 4'd8;
  localparam state_t S_MEMWR  = 4'd9;
  localparam state_t S_BRANCH = 4'd10;
  localparam state_t S_JUMP   = 4'd11;
  localparam state_t S_HOLD   = 4'd12;
  localparam state_t S_HALT   = 4'd13;

  // Opcode class field (top three opcode bits)
  localparam logic [2:0] CLS_R   = 3'b000;
  localparam logic [2:0] CLS_I   = 3'b001;
  localparam logic [2:0] CLS_LW  = 3'b010;
  localparam logic [2:0] CLS_SW  = 3'b011;
  localparam logic [2:0] CLS_BEQ = 3'b100;
  localparam logic [2:0] CLS_BNE = 3'b101;
  localparam logic [2:0] CLS_J   = 3'b110;
  localparam logic [2:0] CLS_SYS = 3'b111;
  localparam logic [2:0] FN_HALT = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_wait_counter.sv
// Memory wait-state counter: counts 0..MEM_LAT-1 while run is high and
// flags the final cycle; returns to zero whenever the memory state is left.
module mc_wait_counter #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic last
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt;

  assign last = run && (cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (run && !last)
      cnt <= cnt + CW'(1);
    else
      cnt <= '0;
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute and drives the
// datapath control word from the opcode and the ALU zero flag.
module mc_control_unit
  import mc_cpu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int MEM_LAT  = 1,
  parameter int STEP_EN  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                zero,
  input  logic                step,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic                MemToReg,
  output logic [1:0]          PCSource,
  output logic                IRWrite,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                RegWrite,
  output logic                instr_done,
  output logic                illegal,
  output logic                halted
);

  state_t     state, state_nxt, done_nxt;
  logic       illegal_set;
  logic       mem_state, wait_last;
  logic [2:0] cls, fn;

  assign cls       = Opcode[OPCODE_W-1 -: 3];
  assign fn        = Opcode[2:0];
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign done_nxt  = (STEP_EN != 0) ? S_HOLD : S_FETCH;

  mc_wait_counter #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk   (clk),
    .rst_n (reset),
    .run   (mem_state),
    .last  (wait_last)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt   = state;
    illegal_set = 1'b0;
    case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  if (wait_last) state_nxt = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_R:           state_nxt = S_EXEC_R;
          CLS_I:           state_nxt = S_EXEC_I;
          CLS_LW, CLS_SW:  state_nxt = S_ADDR;
          CLS_BEQ, CLS_BNE: state_nxt = S_BRANCH;
          CLS_J:           state_nxt = S_JUMP;
          default: begin
            if (fn == FN_HALT) begin
              state_nxt = S_HALT;
            end else begin
              illegal_set = 1'b1;
              state_nxt   = S_FETCH;
            end
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
      S_ADDR:   state_nxt = (cls == CLS_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (wait_last) state_nxt = S_WB_MEM;
      S_MEMWR:  if (wait_last) state_nxt = done_nxt;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_nxt = done_nxt;
      S_HOLD:   if (step) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  // Control word is Moore except the branch write, which folds in zero.
  always_comb begin
    ALUOp       = '0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    MemToReg    = 1'b0;
    PCSource    = PCS_ALU;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    instr_done  = 1'b0;
    case (state)
      S_FETCH: begin
        ALUOp   = ALUOP_W'(ALU_ADD);
        ALUSrcB = SRCB_ONE;
        IRWrite = wait_last;
        PCWrite = wait_last;
      end
      S_DECODE: begin
        ALUOp   = ALUOP_W'(ALU_ADD);
        ALUSrcB = SRCB_IMM;
      end
      S_EXEC_R: begin
        ALUOp   = ALUOP_W'(fn);
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
      end
      S_EXEC_I: begin
        ALUOp   = ALUOP_W'(fn);
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_WB_ALU: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR: begin
        ALUOp   = ALUOP_W'(ALU_ADD);
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = wait_last;
        instr_done = wait_last;
      end
      S_BRANCH: begin
        ALUOp       = ALUOP_W'(ALU_SUB);
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        PCSource    = PCS_ALUOUT;
        PCWriteCond = (cls == CLS_BNE) ? !zero : zero;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: three instances cover MEM_LAT=1,
// MEM_LAT=3 and single-step mode; each cycle's control word is checked.
module tb_mc_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Control word: {ALUOp, SrcA, SrcB, MemToReg, PCSource, IR, MW, PW, PWC, RW, done, illegal, halted}
  function automatic logic [16:0] cw(input logic [2:0] op, input logic sa, input logic [1:0] sb,
                                     input logic m2r, input logic [1:0] pcs, input logic [4:0] en,
                                     input logic done, input logic ill, input logic hlt);
    return {op, sa, sb, m2r, pcs, en, done, ill, hlt};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- instance A: MEM_LAT=1, no stepping ----------------
  logic       a_rst, a_zero, a_step;
  logic [5:0] a_op;
  logic [2:0] a_aluop; logic a_sa; logic [1:0] a_sb; logic a_m2r; logic [1:0] a_pcs;
  logic a_ir, a_mw, a_pw, a_pwc, a_rw, a_done, a_ill, a_hlt;
  logic [16:0] obs_a;
  assign obs_a = {a_aluop, a_sa, a_sb, a_m2r, a_pcs, a_ir, a_mw, a_pw, a_pwc, a_rw, a_done, a_ill, a_hlt};

  mc_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_LAT(1), .STEP_EN(0)) dut_a (
    .clk(clk), .reset(a_rst), .Opcode(a_op), .zero(a_zero), .step(a_step),
    .ALUOp(a_aluop), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .MemToReg(a_m2r), .PCSource(a_pcs),
    .IRWrite(a_ir), .MemWrite(a_mw), .PCWrite(a_pw), .PCWriteCond(a_pwc), .RegWrite(a_rw),
    .instr_done(a_done), .illegal(a_ill), .halted(a_hlt)
  );

  // ---------------- instance B: MEM_LAT=3, no stepping ----------------
  logic       b_rst, b_zero, b_step;
  logic [5:0] b_op;
  logic [2:0] b_aluop; logic b_sa; logic [1:0] b_sb; logic b_m2r; logic [1:0] b_pcs;
  logic b_ir, b_mw, b_pw, b_pwc, b_rw, b_done, b_ill, b_hlt;
  logic [16:0] obs_b;
  assign obs_b = {b_aluop, b_sa, b_sb, b_m2r, b_pcs, b_ir, b_mw, b_pw, b_pwc, b_rw, b_done, b_ill, b_hlt};

  mc_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_LAT(3), .STEP_EN(0)) dut_b (
    .clk(clk), .reset(b_rst), .Opcode(b_op), .zero(b_zero), .step(b_step),
    .ALUOp(b_aluop), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .MemToReg(b_m2r), .PCSource(b_pcs),
    .IRWrite(b_ir), .MemWrite(b_mw), .PCWrite(b_pw), .PCWriteCond(b_pwc), .RegWrite(b_rw),
    .instr_done(b_done), .illegal(b_ill), .halted(b_hlt)
  );

  // ---------------- instance C: MEM_LAT=1, single-step ----------------
  logic       c_rst, c_zero, c_step;
  logic [5:0] c_op;
  logic [2:0] c_aluop; logic c_sa; logic [1:0] c_sb; logic c_m2r; logic [1:0] c_pcs;
  logic c_ir, c_mw, c_pw, c_pwc, c_rw, c_done, c_ill, c_hlt;
  logic [16:0] obs_c;
  assign obs_c = {c_aluop, c_sa, c_sb, c_m2r, c_pcs, c_ir, c_mw, c_pw, c_pwc, c_rw, c_done, c_ill, c_hlt};

  mc_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_LAT(1), .STEP_EN(1)) dut_c (
    .clk(clk), .reset(c_rst), .Opcode(c_op), .zero(c_zero), .step(c_step),
    .ALUOp(c_aluop), .ALUSrcA(c_sa), .ALUSrcB(c_sb), .MemToReg(c_m2r), .PCSource(c_pcs),
    .IRWrite(c_ir), .MemWrite(c_mw), .PCWrite(c_pw), .PCWriteCond(c_pwc), .RegWrite(c_rw),
    .instr_done(c_done), .illegal(c_ill), .halted(c_hlt)
  );

  // Hand-computed control words for the recurring states
  localparam logic [16:0] W_ZERO   = 17'b0;
  localparam logic [16:0] W_FWAIT  = {3'b010, 1'b0, 2'b01, 1'b0, 2'b00, 5'b00000, 3'b000};
  localparam logic [16:0] W_FLAST  = {3'b010, 1'b0, 2'b01, 1'b0, 2'b00, 5'b10100, 3'b000};
  localparam logic [16:0] W_DECODE = {3'b010, 1'b0, 2'b10, 1'b0, 2'b00, 5'b00000, 3'b000};
  localparam logic [16:0] W_ADDR   = {3'b010, 1'b1, 2'b10, 1'b0, 2'b00, 5'b00000, 3'b000};
  localparam logic [16:0] W_WBALU  = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 5'b00001, 3'b100};
  localparam logic [16:0] W_WBMEM  = {3'b000, 1'b0, 2'b00, 1'b1, 2'b00, 5'b00001, 3'b100};
  localparam logic [16:0] W_MEMWR  = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 5'b01000, 3'b100};
  localparam logic [16:0] W_JUMP   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b10, 5'b00100, 3'b100};
  localparam logic [16:0] W_ILL    = 17'b10;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b0; a_zero = 1'b0; a_step = 1'b0; a_op = 6'b0;
    b_rst = 1'b0; b_zero = 1'b0; b_step = 1'b0; b_op = 6'b0;
    c_rst = 1'b0; c_zero = 1'b0; c_step = 1'b0; c_op = 6'b0;

    @(negedge clk);
    check("rst_a", obs_a, W_ZERO);
    check("rst_b", obs_b, W_ZERO);
    check("rst_c", obs_c, W_ZERO);

    // R-type add, then I-type, on MEM_LAT=1
    a_op = 6'b000010; a_rst = 1'b1;
    @(negedge clk); check("r_fetch", obs_a, W_FLAST);
    @(negedge clk); check("r_decode", obs_a, W_DECODE);
    @(negedge clk); check("r_exec", obs_a, cw(3'b010, 1'b1, 2'b00, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0));
    @(negedge clk); check("r_wb", obs_a, W_WBALU);
    a_op = 6'b001101;
    @(negedge clk); check("i_fetch", obs_a, W_FLAST);
    @(negedge clk); check("i_decode", obs_a, W_DECODE);
    @(negedge clk); check("i_exec", obs_a, cw(3'b101, 1'b1, 2'b10, 1'b0, 2'b00, 5'b00000, 1'b0, 1'b0, 1'b0));
    @(negedge clk); check("i_wb", obs_a, W_WBALU);

    // BEQ and BNE, both zero polarities inside the branch cycle
    a_op = 6'b100000; a_zero = 1'b1;
    @(negedge clk); check("beq_fetch", obs_a, W_FLAST);
    @(negedge clk); check("beq_decode", obs_a, W_DECODE);
    @(negedge clk); check("beq_z1", obs_a, cw(3'b011, 1'b1, 2'b00, 1'b0, 2'b01, 5'b00010, 1'b1, 1'b0, 1'b0));
    a_zero = 1'b0; #1;
    check("beq_z0", obs_a, cw(3'b011, 1'b1, 2'b00, 1'b0, 2'b01, 5'b00000, 1'b1, 1'b0, 1'b0));
    a_op = 6'b101000; a_zero = 1'b1;
    @(negedge clk); check("bne_fetch", obs_a, W_FLAST);
    @(negedge clk); check("bne_decode", obs_a, W_DECODE);
    @(negedge clk); check("bne_z1", obs_a, cw(3'b011, 1'b1, 2'b00, 1'b0, 2'b01, 5'b00000, 1'b1, 1'b0, 1'b0));
    a_zero = 1'b0; #1;
    check("bne_z0", obs_a, cw(3'b011, 1'b1, 2'b00, 1'b0, 2'b01, 5'b00010, 1'b1, 1'b0, 1'b0));

    // Jump without stepping returns straight to FETCH
    a_op = 6'b110000;
    @(negedge clk); check("j_fetch", obs_a, W_FLAST);
    @(negedge clk); check("j_decode", obs_a, W_DECODE);
    @(negedge clk); check("j_jump", obs_a, W_JUMP);
    a_op = 6'b111000;
    @(negedge clk); check("ill_fetch0", obs_a, W_FLAST);
    @(negedge clk); check("ill_decode", obs_a, W_DECODE);
    @(negedge clk); check("ill_fetch1", obs_a, W_FLAST | W_ILL);
    a_op = 6'b111111;
    @(negedge clk); check("halt_decode", obs_a, W_DECODE | W_ILL);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); check($sformatf("halt_%0d", i), obs_a, 17'b11);
    end
    a_rst = 1'b0; #1;
    check("halt_rst", obs_a, W_ZERO);

    // LW on MEM_LAT=3
    b_op = 6'b010000; b_rst = 1'b1;
    @(negedge clk); check("lw_f0", obs_b, W_FWAIT);
    @(negedge clk); check("lw_f1", obs_b, W_FWAIT);
    @(negedge clk); check("lw_f2", obs_b, W_FLAST);
    @(negedge clk); check("lw_decode", obs_b, W_DECODE);
    @(negedge clk); check("lw_addr", obs_b, W_ADDR);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check($sformatf("lw_mrd%0d", i), obs_b, W_ZERO);
    end
    @(negedge clk); check("lw_wb", obs_b, W_WBMEM);

    // SW: MemWrite only in last MEMWR cycle
    b_op = 6'b011000;
    @(negedge clk); check("sw_f0", obs_b, W_FWAIT);
    @(negedge clk); check("sw_f1", obs_b, W_FWAIT);
    @(negedge clk); check("sw_f2", obs_b, W_FLAST);
    @(negedge clk); check("sw_decode", obs_b, W_DECODE);
    @(negedge clk); check("sw_addr", obs_b, W_ADDR);
    @(negedge clk); check("sw_m0", obs_b, W_ZERO);
    @(negedge clk); check("sw_m1", obs_b, W_ZERO);
    @(negedge clk); check("sw_m2", obs_b, W_MEMWR);

    // Second SW aborted by reset in its final MEMWR cycle
    @(negedge clk); check("sw2_f0", obs_b, W_FWAIT);
    @(negedge clk); check("sw2_f1", obs_b, W_FWAIT);
    @(negedge clk); check("sw2_f2", obs_b, W_FLAST);
    @(negedge clk); check("sw2_decode", obs_b, W_DECODE);
    @(negedge clk); check("sw2_addr", obs_b, W_ADDR);
    @(negedge clk); check("sw2_m0", obs_b, W_ZERO);
    @(negedge clk); check("sw2_m1", obs_b, W_ZERO);
    @(posedge clk); #1;
    b_rst = 1'b0; #1;
    check("sw2_rst", obs_b, W_ZERO);
    @(negedge clk); check("sw2_rst_hold", obs_b, W_ZERO);
    b_rst = 1'b1; #1;
    check("sw2_idle", obs_b, W_ZERO);
    @(negedge clk); check("rel_f0", obs_b, W_FWAIT);
    @(negedge clk); check("rel_f1", obs_b, W_FWAIT);
    @(negedge clk); check("rel_f2", obs_b, W_FLAST);

    // Single-step: early step ignored, HOLD until a step pulse
    c_op = 6'b110000; c_rst = 1'b1;
    @(negedge clk); check("s_fetch", obs_c, W_FLAST);
    c_step = 1'b1;
    @(negedge clk); check("s_decode", obs_c, W_DECODE);
    c_step = 1'b0;
    @(negedge clk); check("s_jump", obs_c, W_JUMP);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); check($sformatf("s_hold%0d", i), obs_c, W_ZERO);
    end
    c_step = 1'b1;
    @(negedge clk); check("s_resume", obs_c, W_FLAST);
    c_step = 1'b0;
    @(negedge clk); check("s2_decode", obs_c, W_DECODE);
    @(negedge clk); check("s2_jump", obs_c, W_JUMP);
    @(negedge clk); check("s2_hold", obs_c, W_ZERO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
